rx_stream_width_packer: RTL

RX_STREAM_WIDTH_PACKER -- requirements
Module: rx_stream_width_packer

---
 rtl/rx_stream_width_packer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rx_stream_width_packer.sv
// rx_stream_width_packer: packs narrow RX beats into wide words through a small output FIFO,
// with optional preamble/SFD stripping, link-drop truncation and CRC flagging.
// Optional frame timestamp interrupt/sequence logic is enabled by defining RX_PACK_TS_IRQ_EN.
module rx_stream_width_packer #(
    parameter int IN_DATA_WIDTH  = 8,
    parameter int PACK_RATIO     = 4,
    parameter int OUT_DATA_WIDTH = IN_DATA_WIDTH * PACK_RATIO,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_port_link,
    input  logic [1:0]                  i_port_speed,
    input  logic                        i_filter_preamble,
    input  logic [IN_DATA_WIDTH-1:0]    i_data,
    input  logic [IN_DATA_WIDTH/8-1:0]  i_keep,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic                        i_last,
    input  logic                        i_crc_err,
    output logic                        o_time_irq,
    output logic [7:0]                  o_frame_seq,
    output logic [7:0]                  o_ts_addr,
    output logic                        o_port_link,
    output logic [1:0]                  o_port_speed,
    output logic [OUT_DATA_WIDTH:0]     o_data,
    output logic [OUT_DATA_WIDTH/8-1:0] o_keep,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_last
);
    localparam int IKW = IN_DATA_WIDTH / 8;
    localparam int OKW = OUT_DATA_WIDTH / 8;
    localparam int LW  = PACK_RATIO > 1 ? $clog2(PACK_RATIO) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam bit FILT_OK = IN_DATA_WIDTH == 8;

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

    state_t                    state, state_nx;
    logic [2:0]                pre_cnt;
    logic [LW-1:0]             lane;
    logic [OUT_DATA_WIDTH-1:0] acc_data, word_data;
    logic [OKW-1:0]            acc_keep, word_keep;
    logic                      accept, filt, pre_done, pack, push_beat, drop_push, push, push_ok, pop;
    logic [OUT_DATA_WIDTH:0]   push_data;
    logic [OKW-1:0]            push_keep;
    logic                      push_last;
    logic [OUT_DATA_WIDTH:0]   mem_data [FIFO_DEPTH];
    logic [OKW-1:0]            mem_keep [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     mem_last;
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             count;

    assign filt     = i_filter_preamble && FILT_OK;
    assign pre_done = i_data[7:0] == 8'hD5 || (state == PREAMBLE && pre_cnt == 3'd7);

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next state; the IDLE beat of a filtered frame counts as the first preamble byte
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept && i_port_link && !i_last) state_nx = (filt && !pre_done) ? PREAMBLE : PAYLOAD;
            PREAMBLE: if (accept) state_nx = i_last ? IDLE : pre_done ? PAYLOAD : PREAMBLE;
            PAYLOAD:  state_nx = !i_port_link ? ((accept && i_last) ? IDLE : DROP) : (accept && i_last) ? IDLE : PAYLOAD;
            DROP:     if (accept && i_last) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // FSM outputs: handshake, lane merge and FIFO push word
    always_comb begin
        o_ready   = i_rst && (state == DROP || count < CW'(FIFO_DEPTH - 1));
        accept    = i_valid && o_ready;
        pack      = accept && i_port_link && ((state == IDLE && !filt) || state == PAYLOAD);
        word_data = acc_data;
        word_keep = acc_keep;
        for (int k = 0; k < PACK_RATIO; k++) begin
            if (lane == LW'(k)) begin
                word_data[k*IN_DATA_WIDTH +: IN_DATA_WIDTH] = i_data;
                word_keep[k*IKW +: IKW]                     = i_keep;
            end
        end
        push_beat = pack && (lane == LW'(PACK_RATIO - 1) || i_last);
        drop_push = state == PAYLOAD && !i_port_link && lane != '0;
        push      = push_beat || drop_push;
        push_data = drop_push ? {1'b1, acc_data} : {i_last && i_crc_err, word_data};
        push_keep = drop_push ? acc_keep : word_keep;
        push_last = drop_push || i_last;
    end

    // preamble byte counter, restarted from every IDLE cycle
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) pre_cnt <= '0;
        else        pre_cnt <= state == PREAMBLE ? pre_cnt + 3'(accept) : 3'(accept);
    end

    // partial word accumulator; a push always leaves it empty at lane 0
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            lane     <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (push) begin
            lane     <= '0;
            acc_data <= '0;
            acc_keep <= '0;
        end else if (pack) begin
            lane     <= lane + LW'(1);
            acc_data <= word_data;
            acc_keep <= word_keep;
        end
    end

    assign pop     = o_valid && i_ready;
    assign push_ok = push && (count != CW'(FIFO_DEPTH) || pop);

    // FIFO pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    // FIFO storage, no reset needed since reads are gated by occupancy
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= push_data;
            mem_keep[wr_ptr] <= push_keep;
            mem_last[wr_ptr] <= push_last;
        end
    end

    assign o_valid = count != '0;
    assign o_data  = o_valid ? mem_data[rd_ptr] : '0;
    assign o_keep  = o_valid ? mem_keep[rd_ptr] : '0;
    assign o_last  = o_valid && mem_last[rd_ptr];

    // registered port status
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_port_link  <= 1'b0;
            o_port_speed <= '0;
        end else begin
            o_port_link  <= i_port_link;
            o_port_speed <= i_port_speed;
        end
    end

`ifdef RX_PACK_TS_IRQ_EN
    logic sof_pend, sof_now, first_beat;

    assign sof_now    = state == IDLE || sof_pend;
    assign first_beat = pack && sof_now;

    // timestamp pulse and frame sequence on the first packed beat of each frame
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sof_pend    <= 1'b0;
            o_time_irq  <= 1'b0;
            o_frame_seq <= '0;
            o_ts_addr   <= '0;
        end else begin
            sof_pend   <= sof_now && !pack;
            o_time_irq <= first_beat;
            if (first_beat) begin
                o_frame_seq <= o_frame_seq + 8'd1;
                o_ts_addr   <= o_frame_seq;
            end
        end
    end
`else
    assign o_time_irq  = 1'b0;
    assign o_frame_seq = '0;
    assign o_ts_addr   = '0;
`endif
endmodule
